// File: rtl/imm_fetch_pkg.sv
// Shared codes for the immediate-fetch operand stage: ALU function codes,
// immediate modes, FSM state encodings and the byte-extension helper.
package imm_fetch_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_SHR = 4'h6;
    localparam logic [3:0] ALU_X   = 4'hF;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_U8   = 2'd1,
        IMM_S8   = 2'd2,
        IMM_16   = 2'd3
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic [15:0] ext_byte(input imm_mode_e m, input logic [7:0] b);
        return (m == IMM_S8) ? {{8{b[7]}}, b} : {8'h00, b};
    endfunction

endpackage

// File: rtl/imm_fetch.sv
// Operand-issue stage: fetches 0/1/2 immediate bytes and presents fn/src1/src2 to the ALU.
// Optional per-byte memory timeout with err flag under `define IMM_FETCH_TIMEOUT_EN.
module imm_fetch
    import imm_fetch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_fn,
    input  logic [15:0] in_src1,
    input  logic [15:0] in_reg_src2,
    input  logic [1:0]  in_mode,
    input  logic [15:0] in_pc,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  fn,
    output logic [15:0] src1,
    output logic [15:0] src2,
    output logic [15:0] pc_next
`ifdef IMM_FETCH_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
    // valid never depends on ready, and a raised valid holds its payload until the transfer.
    state_e    state;
    state_e    state_next;
    imm_mode_e mode;
    logic [15:0] pc;
    logic [7:0]  lo;
    logic        accept;
    logic        fetching;
    logic        timeout;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign fetching = (state == ST_FETCH_LO) || (state == ST_FETCH_HI);

`ifdef IMM_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !fetching || mem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = fetching && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end else if (state == ST_DONE && out_ready) begin
            err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (imm_mode_e'(in_mode) == IMM_NONE) ? ST_DONE : ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                if (mem_ack) begin
                    state_next = (mode == IMM_16) ? ST_FETCH_HI : ST_DONE;
                end else if (timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_FETCH_HI: begin
                if (mem_ack || timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rd    <= 1'b0;
            mem_addr  <= 16'h0000;
            out_valid <= 1'b0;
            fn        <= ALU_X;
            src1      <= 16'h0000;
            src2      <= 16'h0000;
            pc_next   <= 16'h0000;
            mode      <= IMM_NONE;
            pc        <= 16'h0000;
            lo        <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fn   <= in_fn;
                        src1 <= in_src1;
                        mode <= imm_mode_e'(in_mode);
                        pc   <= in_pc;
                        if (imm_mode_e'(in_mode) == IMM_NONE) begin
                            src2      <= in_reg_src2;
                            pc_next   <= in_pc;
                            out_valid <= 1'b1;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= in_pc;
                        end
                    end
                end
                ST_FETCH_LO: begin
                    if (mem_ack) begin
                        if (mode == IMM_16) begin
                            // mem_rd stays high: the high-byte request follows with no gap
                            lo       <= mem_rdata;
                            mem_addr <= pc + 16'd1;
                        end else begin
                            src2      <= ext_byte(mode, mem_rdata);
                            pc_next   <= pc + 16'd1;
                            mem_rd    <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        src2      <= 16'h0000;
                        pc_next   <= pc;
                        mem_rd    <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ack) begin
                        src2      <= {mem_rdata, lo};
                        pc_next   <= pc + 16'd2;
                        mem_rd    <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (timeout) begin
                        src2      <= 16'h0000;
                        pc_next   <= pc;
                        mem_rd    <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fn        <= ALU_X;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_fetch.sv
// Self-checking bench for imm_fetch: transaction-level model with per-cycle compare,
// directed literal cases, then randomized ops, memory waits, stray acks and resets.
module tb_imm_fetch;
    import imm_fetch_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_fn = 4'h0;
    logic [15:0] in_src1 = 16'h0;
    logic [15:0] in_reg_src2 = 16'h0;
    logic [1:0]  in_mode = 2'd0;
    logic [15:0] in_pc = 16'h0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fn;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] pc_next;
`ifdef IMM_FETCH_TIMEOUT_EN
    logic        err;
`endif

    imm_fetch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fn(in_fn), .in_src1(in_src1),
        .in_reg_src2(in_reg_src2), .in_mode(in_mode), .in_pc(in_pc),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .fn(fn), .src1(src1), .src2(src2), .pc_next(pc_next)
`ifdef IMM_FETCH_TIMEOUT_EN
        , .err(err)
`endif
    );

    // clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fn;
        logic [15:0] src1;
        logic [15:0] src2;
        logic [15:0] pc_next;
        logic [15:0] pc;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  mem_arr [0:65535];

    int checks = 0;
    int failures = 0;

    int resp_fixed = -1;
    int resp_wait_max = 3;
    int ack_budget = -1;
    bit stray_en = 1'b1;
    bit force_ack = 1'b0;
    int w_cnt = 0;
    int w_target = 0;
    int tmo_cnt = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        return (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, resp_wait_max));
    endfunction

    // Reference: what one accepted op must produce, from the memory image.
    function automatic exp_t model_op(input logic [3:0] f, input logic [15:0] s1,
                                      input logic [15:0] rs2, input logic [1:0] m,
                                      input logic [15:0] p);
        exp_t e;
        logic [15:0] p1;
        logic [7:0] b0;
        p1 = p + 16'd1;
        b0 = mem_arr[p];
        e.fn = f;
        e.src1 = s1;
        e.pc = p;
        e.tmo = 1'b0;
        case (m)
            2'd0: begin e.src2 = rs2; e.pc_next = p; end
            2'd1: begin e.src2 = {8'h00, b0}; e.pc_next = p1; end
            2'd2: begin e.src2 = {{8{b0[7]}}, b0}; e.pc_next = p1; end
            default: begin e.src2 = {mem_arr[p1], b0}; e.pc_next = p + 16'd2; end
        endcase
        return e;
    endfunction

    // Scoreboard + memory responder: update model for the edge just passed, compare, then drive the bus.
    always @(negedge clk) begin
        bit m_in_ready, m_out_valid, m_fetch;
        exp_t e;
        m_in_ready  = (exp_q.size() == 0);
        m_fetch     = (exp_addr_q.size() > 0);
        m_out_valid = (exp_q.size() > 0) && !m_fetch;
        if (!rst_n) begin
            exp_q.delete();
            exp_addr_q.delete();
            tmo_cnt = 0;
        end else begin
            if (m_fetch && mem_ack) begin
                void'(exp_addr_q.pop_front());
                tmo_cnt = 0;
            end else if (m_fetch) begin
                tmo_cnt++;
`ifdef IMM_FETCH_TIMEOUT_EN
                if (tmo_cnt == TIMEOUT) begin
                    exp_addr_q.delete();
                    e = exp_q.pop_front();
                    e.src2 = 16'h0000;
                    e.pc_next = e.pc;
                    e.tmo = 1'b1;
                    exp_q.push_front(e);
                    tmo_cnt = 0;
                end
`endif
            end
            if (m_out_valid && out_ready) void'(exp_q.pop_front());
            if (m_in_ready && in_valid) begin
                e = model_op(in_fn, in_src1, in_reg_src2, in_mode, in_pc);
                exp_q.push_back(e);
                if (in_mode != 2'd0) exp_addr_q.push_back(in_pc);
                if (in_mode == 2'd3) exp_addr_q.push_back(in_pc + 16'd1);
            end
        end

        check("in_ready", {15'd0, in_ready}, {15'd0, exp_q.size() == 0});
        check("mem_rd", {15'd0, mem_rd}, {15'd0, exp_addr_q.size() > 0});
        check("out_valid", {15'd0, out_valid},
              {15'd0, (exp_q.size() > 0) && (exp_addr_q.size() == 0)});
        if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q[0]);
        if (exp_q.size() > 0 && exp_addr_q.size() == 0) begin
            check("fn", {12'd0, fn}, {12'd0, exp_q[0].fn});
            check("src1", src1, exp_q[0].src1);
            check("src2", src2, exp_q[0].src2);
            check("pc_next", pc_next, exp_q[0].pc_next);
`ifdef IMM_FETCH_TIMEOUT_EN
            check("err", {15'd0, err}, {15'd0, exp_q[0].tmo});
        end else begin
            check("err_idle", {15'd0, err}, 16'd0);
`endif
        end

        if (force_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 8'($urandom);
        end else if (mem_rd) begin
            if (ack_budget != 0 && w_cnt >= w_target) begin
                mem_ack = 1'b1;
                mem_rdata = mem_arr[mem_addr];
                w_cnt = 0;
                w_target = pick();
                if (ack_budget > 0) ack_budget--;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 8'($urandom);
                w_cnt++;
            end
        end else begin
            mem_ack = stray_en && ($urandom_range(0, 7) == 0);
            mem_rdata = 8'($urandom);
            w_cnt = 0;
            w_target = pick();
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] f, input logic [15:0] s1, input logic [15:0] rs2,
                            input logic [1:0] m, input logic [15:0] p);
        in_valid = 1'b1;
        in_fn = f;
        in_src1 = s1;
        in_reg_src2 = rs2;
        in_mode = m;
        in_pc = p;
    endtask

    task automatic wait_out_valid(input int max_cycles, output int n);
        n = 0;
        while (!out_valid && n < max_cycles) begin
            step();
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_out_valid actual=timeout required=out_valid within %0d cycles", max_cycles);
        end
    endtask

    initial begin
        int n;
        logic [15:0] held;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
        mem_arr[16'h0200] = 8'hF0;
        mem_arr[16'hFFFF] = 8'h34;
        mem_arr[16'h0000] = 8'h12;

        // reset values
        rst_n = 1'b0;
        step(); step(); step();
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_fn", {12'd0, fn}, {12'd0, ALU_X});
        check("rst_src1", src1, 16'h0000);
        check("rst_src2", src2, 16'h0000);
        check("rst_pc_next", pc_next, 16'h0000);
        rst_n = 1'b1;
        step();

        // register operand, 1-cycle latency
        out_ready = 1'b1;
        drive_op(ALU_ADD, 16'h1234, 16'h0011, 2'd0, 16'h0100);
        step();
        in_valid = 1'b0;
        check("none_valid", {15'd0, out_valid}, 16'd1);
        check("none_src2", src2, 16'h0011);
        check("none_pc_next", pc_next, 16'h0100);
        check("none_mem_rd", {15'd0, mem_rd}, 16'd0);
        step();
        check("none_done_fn", {12'd0, fn}, {12'd0, ALU_X});
        check("none_done_ready", {15'd0, in_ready}, 16'd1);

        // 8-bit immediates, zero-wait memory
        resp_fixed = 0;
        step();
        drive_op(ALU_SUB, 16'h0042, 16'hAAAA, 2'd2, 16'h0200);
        step();
        in_valid = 1'b0;
        check("s8_mem_rd", {15'd0, mem_rd}, 16'd1);
        check("s8_mem_addr", mem_addr, 16'h0200);
        step();
        check("s8_valid", {15'd0, out_valid}, 16'd1);
        check("s8_src2", src2, 16'hFFF0);
        check("s8_pc_next", pc_next, 16'h0201);
        step();
        drive_op(ALU_AND, 16'h0042, 16'hAAAA, 2'd1, 16'h0200);
        step();
        in_valid = 1'b0;
        step();
        check("u8_valid", {15'd0, out_valid}, 16'd1);
        check("u8_src2", src2, 16'h00F0);
        check("u8_pc_next", pc_next, 16'h0201);
        step();

        // 16-bit immediate across the address wrap, 2 wait cycles per byte
        resp_fixed = 2;
        step();
        drive_op(ALU_OR, 16'h5555, 16'h0000, 2'd3, 16'hFFFF);
        step();
        in_valid = 1'b0;
        check("w16_first_addr", mem_addr, 16'hFFFF);
        wait_out_valid(20, n);
        check("w16_latency", 16'(n), 16'd6);
        check("w16_src2", src2, 16'h1234);
        check("w16_pc_next", pc_next, 16'h0001);
        step();

        // consumer stall in DONE; an in_valid pulse must not be taken
        resp_fixed = 0;
        out_ready = 1'b0;
        drive_op(ALU_XOR, 16'h0F0F, 16'hBEEF, 2'd0, 16'h0300);
        step();
        in_valid = 1'b0;
        held = src2;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_reg_src2 = 16'h7777;
            step();
            check("stall_valid", {15'd0, out_valid}, 16'd1);
            check("stall_src2", src2, 16'hBEEF);
            check("stall_held", src2, held);
            check("stall_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("stall_release_valid", {15'd0, out_valid}, 16'd0);
        check("stall_release_fn", {12'd0, fn}, {12'd0, ALU_X});
        check("stall_release_ready", {15'd0, in_ready}, 16'd1);

        // reset while waiting on the high byte, then a late ack
        ack_budget = 1;
        drive_op(ALU_SHL, 16'h0001, 16'h0000, 2'd3, 16'h1000);
        step();
        in_valid = 1'b0;
        step();
        check("hi_mem_rd", {15'd0, mem_rd}, 16'd1);
        check("hi_mem_addr", mem_addr, 16'h1001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_hi_mem_rd", {15'd0, mem_rd}, 16'd0);
        check("rst_hi_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_hi_in_ready", {15'd0, in_ready}, 16'd1);
        ack_budget = -1;
        force_ack = 1'b1;
        step(); step();
        force_ack = 1'b0;
        check("late_ack_mem_rd", {15'd0, mem_rd}, 16'd0);
        check("late_ack_out_valid", {15'd0, out_valid}, 16'd0);
        check("late_ack_src2", src2, 16'h0000);

        // memory never answers
        ack_budget = 0;
        out_ready = 1'b0;
        drive_op(ALU_SHR, 16'h0002, 16'h0000, 2'd1, 16'h3000);
        step();
        in_valid = 1'b0;
`ifdef IMM_FETCH_TIMEOUT_EN
        n = 0;
        while (mem_rd && n < 40) begin
            step();
            n++;
        end
        check("tmo_cycles", 16'(n), 16'(TIMEOUT));
        check("tmo_err", {15'd0, err}, 16'd1);
        check("tmo_valid", {15'd0, out_valid}, 16'd1);
        check("tmo_src2", src2, 16'h0000);
        check("tmo_pc_next", pc_next, 16'h3000);
        out_ready = 1'b1;
        step();
        check("tmo_err_clear", {15'd0, err}, 16'd0);
`else
        for (int i = 0; i < 100; i++) step();
        check("noack_mem_rd", {15'd0, mem_rd}, 16'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif
        ack_budget = -1;
        resp_fixed = -1;

        // randomized ops, waits, stray acks and occasional resets
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_fn = 4'($urandom);
            in_src1 = 16'($urandom);
            in_reg_src2 = 16'($urandom);
            in_mode = 2'($urandom);
            in_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
